fetch_sequencer: RTL and testbench

- Owns the architectural PC and the F-stage output register of the five-stage MIPS pipeline.
- Each cycle it selects the next fetch address from one of two sources: sequential PC+4, or the branch/jump target computed in D (delayed-branch semantics).
- Drives a request/ready handshake to instruction memory and obeys pipeline stall and redirect from the hazard unit and D stage.

---
 rtl/fetch_sequencer_if.sv | 10 +
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready channel between the fetch sequencer and imem.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// MIPS F stage: architectural PC, next-PC select with delayed-branch redirect, imem handshake.
// Optional fetch-address checking and HALT state are enabled by defining FETCH_ADDR_CHECK_EN.
module fetch_sequencer #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_WORDS = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                br_valid,
    input  logic [31:0]         br_target,
    fetch_sequencer_if.master   imem,
    output logic                f_valid,
    output logic [31:0]         f_pc,
    output logic [31:0]         f_instr,
    output logic                pc_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1
`ifdef FETCH_ADDR_CHECK_EN
        ,
        HALT  = 2'd2
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        redir_pend;
    logic [31:0] redir_tgt;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic        br_take;
    logic [31:0] next_pc;
    logic        pc_bad;

    assign br_take = br_valid & ~stall;

    // A redirect seen in the cycle its delay slot completes applies immediately.
    assign next_pc = br_take    ? br_target :
                     redir_pend ? redir_tgt : pc + 32'd4;

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [31:0] IMEM_LAST = IMEM_BASE + (IMEM_WORDS << 2) - 32'd4;

    assign pc_bad         = (pc[1:0] != 2'b00) | (pc < IMEM_BASE) | (pc > IMEM_LAST);
    assign imem.imem_addr = pc;
`else
    assign pc_bad         = 1'b0;
    assign imem.imem_addr = {pc[31:2], 2'b00};
`endif

    // NOTE: reset is folded in combinationally so no request escapes while reset is held.
    assign imem.imem_req = reset & (state == FETCH) & ~stall & ~pc_bad;

    // NOTE: all state below uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'd0;
            buf_instr  <= 32'd0;
            buf_pc     <= 32'd0;
            f_valid    <= 1'b0;
            f_pc       <= 32'd0;
            f_instr    <= 32'd0;
            pc_err     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (pc_bad) begin
`ifdef FETCH_ADDR_CHECK_EN
                        pc_err <= 1'b1;
                        state  <= HALT;
`endif
                    end else if (imem.imem_ready) begin
                        if (!stall) begin
                            f_instr    <= imem.imem_rdata;
                            f_pc       <= pc;
                            f_valid    <= 1'b1;
                            pc         <= next_pc;
                            redir_pend <= 1'b0;
                        end else begin
                            // Response raced the stall: park it until F/D unfreezes.
                            buf_instr <= imem.imem_rdata;
                            buf_pc    <= pc;
                            state     <= HOLD;
                        end
                    end else if (br_take) begin
                        redir_pend <= 1'b1;
                        redir_tgt  <= br_target;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        f_instr    <= buf_instr;
                        f_pc       <= buf_pc;
                        f_valid    <= 1'b1;
                        pc         <= next_pc;
                        redir_pend <= 1'b0;
                        state      <= FETCH;
                    end
                end
`ifdef FETCH_ADDR_CHECK_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected F-register contents are queued as fetches are driven.
module tb_fetch_sequencer;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h2400_0000;
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        ready = 1'b1;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        pc_err;

    fetch_sequencer_if bus ();
    assign bus.imem_ready = ready;
    assign bus.imem_rdata = instr_of(bus.imem_addr);

    fetch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .imem      (bus),
        .f_valid   (f_valid),
        .f_pc      (f_pc),
        .f_instr   (f_instr),
        .pc_err    (pc_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb[$];
    logic        seen = 1'b0;
    logic [31:0] last_pc = 32'd0;

    // Reference model of the architectural PC
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each new F-register value is popped from the scoreboard and compared.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (!reset) begin
            seen = 1'b0;
        end else if (f_valid && (!seen || f_pc != last_pc)) begin
            seen    = 1'b1;
            last_pc = f_pc;
            if (sb.size() == 0) begin
                check("sb_unexpected_fpc", f_pc, 32'hFFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                check("f_pc", f_pc, exp);
                check("f_instr", f_instr, instr_of(exp));
            end
        end
    end

    task automatic do_reset();
        check("sb_empty_before_reset", 32'(sb.size()), 32'd0);
        reset = 1'b0; stall = 1'b0; br_valid = 1'b0; ready = 1'b1;
        m_pc = 32'h0000_3000; m_pend = 1'b0; m_tgt = 32'd0;
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_f_valid", 32'(f_valid), 32'd0);
        check("rst_f_pc", f_pc, 32'd0);
        check("rst_f_instr", f_instr, 32'd0);
        check("rst_pc_err", 32'(pc_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, m_pc);
    endtask

    task automatic fetch_cycle(input logic br = 1'b0, input logic [31:0] tgt = 32'd0);
        ready = 1'b1; stall = 1'b0; br_valid = br; br_target = tgt;
        sb.push_back(m_pc);
        if (br)          m_pc = tgt;
        else if (m_pend) m_pc = m_tgt;
        else             m_pc = m_pc + 32'd4;
        m_pend = 1'b0;
        @(posedge clk);
        #1 br_valid = 1'b0;
    endtask

    task automatic wait_cycle(input logic br = 1'b0, input logic [31:0] tgt = 32'd0);
        ready = 1'b0; stall = 1'b0; br_valid = br; br_target = tgt;
        if (br) begin
            m_pend = 1'b1;
            m_tgt  = tgt;
        end
        #1;
        check("wait_req", 32'(bus.imem_req), 32'd1);
        check("wait_addr", bus.imem_addr, m_pc);
        @(posedge clk);
        #1 br_valid = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1 check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Sequential stream, then taken beq at 300C (redirect while 3010 completes)
        do_reset();
        check("f_valid_before_first_edge", 32'(f_valid), 32'd0);
        repeat (4) fetch_cycle();
        fetch_cycle(1'b1, 32'h0000_3040);
        repeat (2) fetch_cycle();
        drain();

        // Three wait cycles on 3014, then redirect captured while 301C is outstanding
        do_reset();
        repeat (5) fetch_cycle();
        repeat (3) begin
            wait_cycle();
            check("wait_f_pc", f_pc, 32'h0000_3010);
        end
        repeat (2) fetch_cycle();
        wait_cycle(1'b1, 32'h0000_3080);
        repeat (2) fetch_cycle();
        drain();

        // Stall racing the 3020 response: buffer, HOLD, release, then request 3024
        do_reset();
        repeat (8) fetch_cycle();
        stall = 1'b1; ready = 1'b1;
        #1 check("stall_req", 32'(bus.imem_req), 32'd0);
        sb.push_back(m_pc);
        m_pc = m_pc + 32'd4;
        @(posedge clk);
        #1 ready = 1'b0;
        #1;
        check("hold_req", 32'(bus.imem_req), 32'd0);
        check("hold_f_pc", f_pc, 32'h0000_301C);
        @(posedge clk);
        #1 stall = 1'b0; ready = 1'b1;
        #1 check("hold_release_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1;
        check("resume_req", 32'(bus.imem_req), 32'd1);
        check("resume_addr", bus.imem_addr, 32'h0000_3024);
        fetch_cycle();
        drain();

        // Branch during stall is ignored; only the later assertion redirects
        do_reset();
        repeat (3) fetch_cycle();
        stall = 1'b1; ready = 1'b0; br_valid = 1'b1; br_target = 32'h0000_3200;
        #1 check("stalled_br_req", 32'(bus.imem_req), 32'd0);
        @(posedge clk);
        #1 br_valid = 1'b0;
        fetch_cycle();
        fetch_cycle(1'b1, 32'h0000_3100);
        repeat (2) fetch_cycle();
        drain();
        check("pc_err_clear", 32'(pc_err), 32'd0);

`ifdef FETCH_ADDR_CHECK_EN
        // jr to a misaligned target halts fetch with a sticky error
        do_reset();
        repeat (3) fetch_cycle();
        fetch_cycle(1'b1, 32'h0000_3002);
        ready = 1'b1;
        #1 check("bad_addr_visible", bus.imem_addr, 32'h0000_3002);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("halt_pc_err", 32'(pc_err), 32'd1);
            check("halt_req", 32'(bus.imem_req), 32'd0);
            check("halt_f_pc", f_pc, 32'h0000_300C);
        end
`endif

        reset = 1'b0;
        #1 check("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
